// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared receiver state encoding and index-width helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Width of the data-bit index; never narrower than one bit.
    function automatic int idx_width(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Show-ahead synchronous FIFO; head entry is visible on o_head.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module : uart_rx_fifo
// Brief  : 8N1 UART receiver with two-flop synchroniser feeding a small FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_W       = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic                            rx_i,
    input  logic                            rd_en_i,
    input  logic                            clr_err_i,
    output logic [DATA_W-1:0]               data_o,
    output logic                            valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
    output logic                            overrun_o,
    output logic                            frame_err_o
);

    import uart_pkg::*;

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IDX_W = idx_width(DATA_W);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_W - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               w_rxs;
    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [DATA_W-1:0]  r_shreg;
    logic [DATA_W-1:0]  w_shreg_nxt;
    logic               w_push;
    logic               w_ferr_set;
    logic               w_ovr_set;
    logic               w_full;
    logic               w_empty;
    logic               r_overrun;
    logic               r_frame_err;

    assign w_rxs = r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx_i;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shreg     <= w_shreg_nxt;
            // A fresh error in the clear cycle wins over the clear.
            r_overrun   <= w_ovr_set  | (r_overrun   & ~clr_err_i);
            r_frame_err <= w_ferr_set | (r_frame_err & ~clr_err_i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shreg_nxt = r_shreg;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxs) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt          = '0;
                    w_shreg_nxt[r_idx] = w_rxs;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold here until the line releases so a long break reports once.
                w_cnt_nxt = '0;
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (!ena) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_push      = 1'b0;
            w_ferr_set  = 1'b0;
        end
    end

    assign w_ovr_set = w_push & w_full & ~(rd_en_i & ~w_empty);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (r_shreg),
        .i_pop       (rd_en_i),
        .o_head      (data_o),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (count_o)
    );

    assign valid_o     = ~w_empty;
    assign overrun_o   = r_overrun;
    assign frame_err_o = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module : tb_uart_rx_fifo
// Brief  : Scoreboard bench for uart_rx_fifo at 8 clk/bit, 4-entry FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int HALF  = CPB / 2;
    // Cycle within a frame (relative to the start-bit drive) whose edge pushes.
    localparam int PUSH_CYC = 2 + HALF + 9 * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b1;
    logic          rx_i = 1'b1;
    logic          rd_en_i = 1'b0;
    logic          clr_err_i = 1'b0;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic [2:0]    count_o;
    logic          overrun_o;
    logic          frame_err_o;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] q_exp[$];
    logic          exp_ovr = 1'b0;
    logic          exp_ferr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_W       (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .rx_i        (rx_i),
        .rd_en_i     (rd_en_i),
        .clr_err_i   (clr_err_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .count_o     (count_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_count"}, 32'(count_o), 32'(q_exp.size()));
        chk({tag, "_valid"}, 32'(valid_o), 32'(q_exp.size() != 0));
        chk({tag, "_ovr"},   32'(overrun_o), 32'(exp_ovr));
        chk({tag, "_ferr"},  32'(frame_err_o), 32'(exp_ferr));
    endtask

    // pop_cyc: cycle on which to pulse rd_en_i (-1 none); abort_cyc: cycle to hit reset (-1 none).
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit,
                              input int pop_cyc, input int abort_cyc);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c == abort_cyc) begin
                rst     = 1'b1;
                rx_i    = 1'b1;
                rd_en_i = 1'b0;
                tick(2);
                rst = 1'b0;
                q_exp.delete();
                exp_ovr  = 1'b0;
                exp_ferr = 1'b0;
                return;
            end
            rx_i = bits[c / CPB];
            if (c == pop_cyc) begin
                chk("pop_on_push_data", 32'(data_o), 32'(q_exp[0]));
                void'(q_exp.pop_front());
                rd_en_i = 1'b1;
            end else begin
                rd_en_i = 1'b0;
            end
            tick(1);
        end
        rd_en_i = 1'b0;
        rx_i    = 1'b1;
        if (stop_bit) begin
            if (q_exp.size() >= DEPTH) exp_ovr = 1'b1;
            else q_exp.push_back(d);
        end else begin
            exp_ferr = 1'b1;
        end
        tick(2);
    endtask

    task automatic pop_chk(input string tag);
        logic [DW-1:0] e;
        e = '0;
        if (q_exp.size() > 0) e = q_exp.pop_front();
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        chk({tag, "_data"},  32'(data_o), 32'(e));
        rd_en_i = 1'b1;
        tick(1);
        rd_en_i = 1'b0;
        chk({tag, "_count"}, 32'(count_o), 32'(q_exp.size()));
    endtask

    task automatic clear_errors();
        clr_err_i = 1'b1;
        tick(1);
        clr_err_i = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_data", 32'(data_o), 32'd0);
        check_status("rst");
        rst = 1'b0;
        tick(2);

        // Single frame, then pop
        send_frame(8'hA5, 1'b1, -1, -1);
        check_status("t1");
        pop_chk("t1_pop");

        // Overfill: fifth frame is dropped
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1);
        check_status("t2_full");
        for (int i = 0; i < 4; i++) pop_chk($sformatf("t2_pop%0d", i));
        clear_errors();
        check_status("t2_clr");

        // Short low glitch is rejected; receiver still works afterwards
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(20);
        check_status("t3_glitch");
        send_frame(8'h96, 1'b1, -1, -1);
        pop_chk("t3_after");

        // Framing error, then clear
        send_frame(8'h3C, 1'b0, -1, -1);
        tick(4);
        check_status("t4_ferr");
        clear_errors();
        tick(2 * CPB);
        check_status("t4_clr");

        // Full FIFO with a pop on the push cycle
        send_frame(8'h10, 1'b1, -1, -1);
        send_frame(8'h20, 1'b1, -1, -1);
        send_frame(8'h30, 1'b1, -1, -1);
        send_frame(8'h40, 1'b1, -1, -1);
        check_status("t5_full");
        send_frame(8'h77, 1'b1, PUSH_CYC, -1);
        check_status("t5_pushpop");
        for (int i = 0; i < 4; i++) pop_chk($sformatf("t5_pop%0d", i));

        // Reset in the middle of a frame, then a clean frame
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h5A, 1'b1, -1, 4 * CPB);
        chk("t6_rst_data", 32'(data_o), 32'd0);
        check_status("t6_rst");
        tick(2 * CPB);
        check_status("t6_idle");
        send_frame(8'hC3, 1'b1, -1, -1);
        check_status("t6_rx");
        pop_chk("t6_pop");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
